// File: rtl/io_bus_bridge_pkg.sv
// Shared definitions for the MEM-stage IO bus and its downstream bridge.
package mem_definitions;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } bridge_state_t;

  // Upper 24 address bits that select the IO window; the MEM stage qualifies these.
  localparam logic [23:0] IO_MEM_SPACE = 24'h000000;

  // Read data returned when a peripheral never answers.
  localparam logic [31:0] IO_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/io_bus_bridge_timer.sv
// Saturating wait-state counter; flags expiry once TIMEOUT_CYCLES is reached.
module bus_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES));

  // Count enabled cycles, holding at the limit; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/io_bus_bridge.sv
// IO bus bridge: decodes single MEM-stage requests onto NUM_SLOTS peripheral
// slots with a held-strobe handshake, wait states and a timeout.
module io_bus_bridge
  import mem_definitions::*;
#(
  parameter int          NUM_SLOTS      = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = IO_ERR_DATA
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   b_addr_i,
  input  logic [31:0]                   b_data_i,
  input  logic                          b_read_i,
  input  logic                          b_write_i,
  output logic [31:0]                   b_data_o,
  output logic                          b_ack_o,
  output logic [NUM_SLOTS-1:0]          p_sel,
  output logic [7-$clog2(NUM_SLOTS):0]  p_addr,
  output logic [31:0]                   p_wdata,
  output logic                          p_read,
  output logic                          p_write,
  input  logic [NUM_SLOTS*32-1:0]       p_rdata,
  input  logic [NUM_SLOTS-1:0]          p_ready,
  input  logic                          err_clr,
  output logic                          bus_err
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int OFF_W  = 8 - SLOT_W;

  bridge_state_t     state;
  bridge_state_t     state_next;
  logic [SLOT_W-1:0] slot_q;
  logic              write_q;
  logic              req;
  logic              both_req;
  logic              ready_sel;
  logic [31:0]       rdata_sel;
  logic              expired;
  logic              err_set;
  logic              unused_upper_addr;

  assign req       = b_read_i | b_write_i;
  assign both_req  = b_read_i & b_write_i;
  assign ready_sel = p_ready[slot_q];
  assign rdata_sel = p_rdata[{slot_q, 5'b00000} +: 32];
  assign err_set   = ((state == IDLE) && both_req) ||
                     ((state == ACCESS) && expired && !ready_sel);

  assign unused_upper_addr = ^b_addr_i[31:8];

  // Counting starts on entry to ACCESS so that expiry lands on the last allowed cycle.
  bus_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ACK),
    .enable (state_next == ACCESS),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus strobes decoded from state so reset drops them immediately.
  always_comb begin
    state_next = state;
    p_sel      = '0;
    p_read     = 1'b0;
    p_write    = 1'b0;
    b_ack_o    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        p_sel   = NUM_SLOTS'(1) << slot_q;
        p_read  = !write_q;
        p_write = write_q;
        if (ready_sel || expired) begin
          state_next = ACK;
        end
      end
      ACK: begin
        b_ack_o    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request in IDLE and return data when the access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      write_q  <= 1'b0;
      p_addr   <= '0;
      p_wdata  <= '0;
      b_data_o <= '0;
    end else if (state == IDLE) begin
      if (req) begin
        slot_q  <= b_addr_i[7:OFF_W];
        p_addr  <= b_addr_i[OFF_W-1:0];
        p_wdata <= b_data_i;
        write_q <= b_write_i;
      end
    end else if (state == ACCESS) begin
      if (ready_sel) begin
        b_data_o <= write_q ? 32'h0 : rdata_sel;
      end else if (expired) begin
        b_data_o <= write_q ? 32'h0 : ERR_DATA;
      end
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err <= 1'b0;
    end else if (err_set) begin
      bus_err <= 1'b1;
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Scoreboard bench for io_bus_bridge with a behavioural peripheral model.
module tb_io_bus_bridge;

  localparam int          NS   = 4;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       b_addr_i = '0;
  logic [31:0]       b_data_i = '0;
  logic              b_read_i = 1'b0;
  logic              b_write_i = 1'b0;
  logic [31:0]       b_data_o;
  logic              b_ack_o;
  logic [NS-1:0]     p_sel;
  logic [5:0]        p_addr;
  logic [31:0]       p_wdata;
  logic              p_read;
  logic              p_write;
  logic [NS*32-1:0]  p_rdata;
  logic [NS-1:0]     p_ready = '0;
  logic              err_clr = 1'b0;
  logic              bus_err;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            delay_cfg[NS];
  logic [31:0]   rdata_cfg[NS];
  logic [NS-1:0] noise_mask = '0;
  logic [NS-1:0] rdy;
  int            wait_cnt = 0;
  logic          err_model = 1'b0;
  logic [31:0]   last_data = '0;

  io_bus_bridge #(
    .NUM_SLOTS     (NS),
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA      (ERRD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .b_addr_i (b_addr_i),
    .b_data_i (b_data_i),
    .b_read_i (b_read_i),
    .b_write_i(b_write_i),
    .b_data_o (b_data_o),
    .b_ack_o  (b_ack_o),
    .p_sel    (p_sel),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_read   (p_read),
    .p_write  (p_write),
    .p_rdata  (p_rdata),
    .p_ready  (p_ready),
    .err_clr  (err_clr),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  assign p_rdata = {rdata_cfg[3], rdata_cfg[2], rdata_cfg[1], rdata_cfg[0]};

  // Peripheral model: the selected slot answers after delay_cfg wait cycles.
  always @(posedge clk) begin
    #1;
    rdy = noise_mask;
    if (p_read || p_write) begin
      for (int k = 0; k < NS; k++) begin
        if (p_sel[k] && wait_cnt >= delay_cfg[k]) rdy[k] = 1'b1;
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    p_ready = rdy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive one request, push its expectation, wait for the ack and score it.
  // extra = 1 when the request is driven during the previous ACK cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rd, input logic wr, input int extra);
    exp_t        e;
    exp_t        got_e;
    logic [1:0]  slot;
    logic [5:0]  off;
    logic [NS-1:0] exp_sel;
    bit          tmo;
    int          cyc;
    int          acc_seen;
    bit          done;
    slot    = addr[7:6];
    off     = addr[5:0];
    exp_sel = 4'b0001 << slot;
    tmo     = (delay_cfg[slot] >= TO);
    e.acc   = tmo ? TO : delay_cfg[slot] + 1;
    e.lat   = e.acc + 1 + extra;
    e.data  = wr ? 32'h0 : (tmo ? ERRD : rdata_cfg[slot]);
    if ((rd && wr) || tmo) err_model = 1'b1;
    sb.push_back(e);
    b_addr_i  = addr;
    b_data_i  = wdata;
    b_read_i  = rd;
    b_write_i = wr;
    cyc = 0;
    acc_seen = 0;
    done = 0;
    while (!done && cyc < 60) begin
      @(posedge clk);
      #2;
      cyc++;
      if (p_sel == exp_sel && p_addr == off && p_read == !wr && p_write == wr &&
          (!wr || p_wdata == wdata)) acc_seen++;
      if (b_ack_o) done = 1;
    end
    got_e = sb.pop_front();
    if (!done) begin
      checkOutput("ack_wait", 32'd0, 32'd1);
    end else begin
      checkOutput("rdata", b_data_o, got_e.data);
      checkOutput("latency", cyc, got_e.lat);
      checkOutput("access_cycles", acc_seen, got_e.acc);
      checkOutput("bus_err", {31'd0, bus_err}, {31'd0, err_model});
      last_data = got_e.data;
    end
  endtask

  task automatic idleBus();
    b_read_i  = 1'b0;
    b_write_i = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("ack_one_cycle", {31'd0, b_ack_o}, 32'd0);
    checkOutput("data_hold", b_data_o, last_data);
  endtask

  task automatic errClear();
    err_clr = 1'b1;
    @(posedge clk);
    #2;
    err_clr = 1'b0;
    err_model = 1'b0;
    checkOutput("err_clr", {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NS; k++) begin
      delay_cfg[k] = 0;
      rdata_cfg[k] = 32'h1000_0000 + k;
    end
    rdata_cfg[1] = 32'h12345678;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_ack", {31'd0, b_ack_o}, 32'd0);
    checkOutput("rst_sel", {28'd0, p_sel}, 32'd0);
    checkOutput("rst_strobes", {30'd0, p_read, p_write}, 32'd0);
    checkOutput("rst_err", {31'd0, bus_err}, 32'd0);
    checkOutput("rst_data", b_data_o, 32'd0);
    checkOutput("rst_addr", {26'd0, p_addr}, 32'd0);
    checkOutput("rst_wdata", p_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // zero-wait read of slot 1
    applyStimulus(32'h44, 32'h0, 1'b1, 1'b0, 0);
    idleBus();

    // write with five wait states
    delay_cfg[3] = 5;
    applyStimulus(32'hC8, 32'hCAFEF00D, 1'b0, 1'b1, 0);
    idleBus();

    // timeout on an unresponsive slot, then clear the error
    delay_cfg[2] = 100;
    applyStimulus(32'h80, 32'h0, 1'b1, 1'b0, 0);
    idleBus();
    errClear();

    // back-to-back reads, second driven during the ACK cycle
    delay_cfg[2] = 0;
    rdata_cfg[0] = 32'hA5A50001;
    rdata_cfg[1] = 32'h5A5A0002;
    applyStimulus(32'h10, 32'h0, 1'b1, 1'b0, 0);
    applyStimulus(32'h7C, 32'h0, 1'b1, 1'b0, 1);
    idleBus();

    // simultaneous read and write: write wins and flags an error
    applyStimulus(32'h88, 32'h55AA55AA, 1'b1, 1'b1, 0);
    idleBus();
    errClear();

    // ready from other slots must not end the access early
    delay_cfg[2] = 3;
    rdata_cfg[2] = 32'h0BADF00D;
    noise_mask = 4'b1011;
    applyStimulus(32'h84, 32'h0, 1'b1, 1'b0, 0);
    noise_mask = '0;
    idleBus();

    // a few mixed transactions
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic        w;
      a = $urandom;
      w = 1'($urandom_range(0, 1));
      delay_cfg[a[7:6]] = $urandom_range(0, 3);
      rdata_cfg[a[7:6]] = $urandom;
      applyStimulus(a, $urandom, !w, w, 0);
      idleBus();
    end

    // reset in the middle of an access
    delay_cfg[2] = 100;
    b_addr_i = 32'h80;
    b_read_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("pre_reset_sel", {28'd0, p_sel}, 32'h4);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_sel", {28'd0, p_sel}, 32'd0);
    checkOutput("reset_read", {31'd0, p_read}, 32'd0);
    checkOutput("reset_ack", {31'd0, b_ack_o}, 32'd0);
    b_read_i = 1'b0;
    err_model = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("reset_no_ack", {31'd0, b_ack_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    last_data = 32'h0;
    delay_cfg[2] = 1;
    applyStimulus(32'h80, 32'h0, 1'b1, 1'b0, 0);
    idleBus();

    // unknown request lines count as no request
    b_read_i  = 1'bx;
    b_write_i = 1'bx;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("x_req_sel", {28'd0, p_sel}, 32'd0);
    b_read_i  = 1'b0;
    b_write_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
